alu_op_decoder: RTL



---
 rtl/alu_op_decoder_if.sv | 44 ++++
 rtl/alu_op_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_decoder_if.sv
// Bus bundle between the instruction source / register file and the ALU
// front end. The decoder takes the master side; the surrounding environment
// (fetch, register file, ALU/writeback) takes the slave side.
// Optional macro ALU_DEC_ILLEGAL_TRAP_EN adds the illegalOp signal.
interface alu_op_decoder_if #(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32
) ();
   logic                  instrValid;
   logic                  instrReady;
   logic [31:0]           instr;
   logic [REG_ADDR_W-1:0] rfAddr1;
   logic [REG_ADDR_W-1:0] rfAddr2;
   logic [DATA_W-1:0]     rfData1;
   logic [DATA_W-1:0]     rfData2;
   logic                  aluValid;
   logic                  aluReady;
   logic [4:0]            func;
   logic [DATA_W-1:0]     dataIn1;
   logic [DATA_W-1:0]     dataIn2;
   logic [REG_ADDR_W-1:0] destReg;
   logic                  isStore;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
   logic                  illegalOp;
`endif

   modport master (
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
      output illegalOp,
`endif
      input  instrValid, instr, rfData1, rfData2, aluReady,
      output instrReady, rfAddr1, rfAddr2, aluValid, func,
             dataIn1, dataIn2, destReg, isStore
   );

   modport slave (
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
      input  illegalOp,
`endif
      output instrValid, instr, rfData1, rfData2, aluReady,
      input  instrReady, rfAddr1, rfAddr2, aluValid, func,
             dataIn1, dataIn2, destReg, isStore
   );
endinterface

// File: rtl/alu_op_decoder.sv
// ALU front end: 2-stage pipeline (S1 decode/register read, S2 operands)
// with valid/ready handshakes on both sides and full backpressure.
// Optional macro ALU_DEC_ILLEGAL_TRAP_EN: unmapped ops are dropped in S1 and
// flagged by a one-cycle illegalOp pulse instead of decoding as ADD.
module alu_op_decoder #(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32
) (
   input logic              clk,
   input logic              rstN,
   alu_op_decoder_if.master bus
);
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00100;
   localparam logic [4:0] OP_OR   = 5'b00101;
   localparam logic [4:0] OP_XOR  = 5'b00110;
   localparam logic [4:0] OP_NAND = 5'b01100;
   localparam logic [4:0] OP_NOR  = 5'b01101;
   localparam logic [4:0] OP_XNOR = 5'b01110;
   localparam logic [4:0] OP_MVHI = 5'b01011;
   localparam logic [4:0] OP_LD   = 5'b10000;
   localparam logic [4:0] OP_ST   = 5'b10001;

   // ALU ops pass their opcode straight through as func; LD/ST compute an
   // address with ADD, and anything unmapped also lands on ADD.
   function automatic logic [4:0] decode_func(input logic [4:0] op);
      logic [4:0] f;
      case (op)
         OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND,
         OP_NOR, OP_XNOR, OP_MVHI: f = op;
         default:                  f = OP_ADD;
      endcase
      return f;
   endfunction

`ifdef ALU_DEC_ILLEGAL_TRAP_EN
   function automatic logic op_is_mapped(input logic [4:0] op);
      logic m;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND,
         OP_NOR, OP_XNOR, OP_MVHI, OP_LD, OP_ST: m = 1'b1;
         default:                                m = 1'b0;
      endcase
      return m;
   endfunction
`endif

   // Operand 2 selection: LD/ST always take the sign-extended offset; other
   // ops use the register unless the immediate flag is set, in which case
   // logical ops zero-extend, MVHI places imm16 in the upper half and
   // arithmetic (and unmapped) ops sign-extend.
   function automatic logic [DATA_W-1:0] select_operand2(
      input logic [4:0]        op,
      input logic              imm_flag,
      input logic [15:0]       imm,
      input logic [DATA_W-1:0] rf_val
   );
      logic signed [15:0]       imm_s;
      logic signed [DATA_W-1:0] sext;
      logic [DATA_W-1:0]        zext;
      logic [DATA_W-1:0]        res;
      imm_s = imm;
      sext  = DATA_W'(imm_s);
      zext  = {{(DATA_W-16){1'b0}}, imm};
      if (op == OP_LD || op == OP_ST) begin
         res = sext;
      end else if (!imm_flag) begin
         res = rf_val;
      end else begin
         case (op)
            OP_AND, OP_OR, OP_XOR,
            OP_NAND, OP_NOR, OP_XNOR: res = zext;
            OP_MVHI:                  res = zext << 16;
            default:                  res = sext;
         endcase
      end
      return res;
   endfunction

   logic                  vld_p1_q, vld_p1_d;
   logic [31:0]           instr_p1_q, instr_p1_d;
   logic                  alu_valid_q, alu_valid_d;
   logic [4:0]            func_q, func_d;
   logic [DATA_W-1:0]     data1_q, data1_d;
   logic [DATA_W-1:0]     data2_q, data2_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   logic                  store_q, store_d;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
   logic                  illegal_q, illegal_d;
`endif
   logic                  s2_ready, s1_adv, s1_load, s2_load, instr_ready;
   logic [4:0]            op_p1;

   // Handshake control: S1 moves on whenever S2 is empty or draining this cycle
   always_comb begin
      s2_ready    = !alu_valid_q || bus.aluReady;
      s1_adv      = vld_p1_q && s2_ready;
      instr_ready = !vld_p1_q || s1_adv;
      s1_load     = bus.instrValid && instr_ready;
   end

   // ---- Stage S1: instruction register (loads on accept, holds on stall) ----
   always_comb begin
      vld_p1_d   = vld_p1_q;
      instr_p1_d = instr_p1_q;
      if (s1_load) begin
         vld_p1_d   = 1'b1;
         instr_p1_d = bus.instr;
      end else if (s1_adv) begin
         vld_p1_d = 1'b0;
      end
   end

   // The synchronous-read register file samples its address on the same edge
   // that loads S1, so it is given the S1 register's next value; its data is
   // then valid while the instruction sits in S1, and a held S1 keeps the
   // address (and therefore the data) stable for re-capture.
   assign bus.rfAddr1 = REG_ADDR_W'(instr_p1_d[20:16]);
   assign bus.rfAddr2 = REG_ADDR_W'(instr_p1_d[15:11]);

   // ---- Stage S2: decode and operand capture (holds while output stalled) ----
   always_comb begin
      op_p1       = instr_p1_q[31:27];
      alu_valid_d = alu_valid_q;
      func_d      = func_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      dest_d      = dest_q;
      store_d     = store_q;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
      s2_load     = s1_adv && op_is_mapped(op_p1);
      illegal_d   = s1_adv && !op_is_mapped(op_p1);
`else
      s2_load     = s1_adv;
`endif
      if (s2_load) begin
         alu_valid_d = 1'b1;
         func_d      = decode_func(op_p1);
         data1_d     = bus.rfData1;
         data2_d     = select_operand2(op_p1, instr_p1_q[26], instr_p1_q[15:0], bus.rfData2);
         dest_d      = REG_ADDR_W'(instr_p1_q[25:21]);
         store_d     = (op_p1 == OP_ST);
      end else if (bus.aluReady) begin
         alu_valid_d = 1'b0;
      end
   end

   // Pipeline state; reset clears both stages and discards in-flight work
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         vld_p1_q    <= 1'b0;
         instr_p1_q  <= '0;
         alu_valid_q <= 1'b0;
         func_q      <= '0;
         data1_q     <= '0;
         data2_q     <= '0;
         dest_q      <= '0;
         store_q     <= 1'b0;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
         illegal_q   <= 1'b0;
`endif
      end else begin
         vld_p1_q    <= vld_p1_d;
         instr_p1_q  <= instr_p1_d;
         alu_valid_q <= alu_valid_d;
         func_q      <= func_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         dest_q      <= dest_d;
         store_q     <= store_d;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
         illegal_q   <= illegal_d;
`endif
      end
   end

   assign bus.instrReady = instr_ready;
   assign bus.aluValid   = alu_valid_q;
   assign bus.func       = func_q;
   assign bus.dataIn1    = data1_q;
   assign bus.dataIn2    = data2_q;
   assign bus.destReg    = dest_q;
   assign bus.isStore    = store_q;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
   assign bus.illegalOp  = illegal_q;
`endif
endmodule
